// File: rtl/sha256_pkg.sv
// Shared constants, chunk type and padder state encoding for the SHA-256 front end.
package sha256_pkg;

  localparam int          SHA256_BLOCK_WORDS  = 16;
  localparam logic [31:0] SHA256_PAD_WORD     = 32'h8000_0000;
  localparam int          SHA256_LEN_WORD_IDX = 14;

  typedef logic [SHA256_BLOCK_WORDS-1:0][31:0] chunk_t;

  typedef enum logic [1:0] {
    ST_ACCEPT,
    ST_EMIT,
    ST_SPILL,
    ST_FINAL
  } pad_state_t;

  // Byte counts above a full word behave as a full word.
  function automatic logic [2:0] clamp_nbytes(input logic [2:0] n);
    return (n > 3'd4) ? 3'd4 : n;
  endfunction

endpackage

// File: rtl/sha256_pad_word.sv
// Keeps the top n bytes of a big-endian word, places the 0x80 terminator at byte n
// and zeroes the bytes below it; n=4 passes the word through untouched.
module sha256_pad_word
  import sha256_pkg::*;
(
  input  logic [31:0] data,
  input  logic [2:0]  n,
  output logic [31:0] word
);

  always_comb begin
    word = data;
    if (n < 3'd4) begin
      for (int b = 0; b < 4; b++) begin
        if (3'(b) == n)
          word[31-8*b -: 8] = SHA256_PAD_WORD[31:24];
        else if (3'(b) > n)
          word[31-8*b -: 8] = 8'h00;
      end
    end
  end

endmodule

// File: rtl/sha256_padder.sv
// SHA-256 message padder: packs 32-bit words into 512-bit chunks with terminator and length.
// Define SHA256_PADDER_OBUF_EN for a separate output chunk register (no input bubbles).
module sha256_padder
  import sha256_pkg::*;
#(
  parameter int LEN_W = 32
) (
  input  logic                                clk,
  input  logic                                rst,
  output logic                                msg_rdy,
  input  logic                                msg_vld,
  input  logic [31:0]                         msg_data,
  input  logic                                msg_last,
  input  logic [2:0]                          msg_nbytes,
  input  logic                                chunk_data_rdy,
  output logic                                chunk_data_vld,
  output logic [SHA256_BLOCK_WORDS-1:0][31:0] chunk_data,
  output logic                                chunk_last
);

  pad_state_t       state;
  logic [3:0]       widx;
  logic [LEN_W-1:0] cnt;
  logic             pend;
  chunk_t           acc;

  chunk_t           blk;
  logic [2:0]       n_eff;
  logic [31:0]      pword;
  logic [LEN_W-1:0] cnt_nx;
  logic [4:0]       used;
  logic             pend_nx;
  logic [63:0]      len_nx;
  logic             accept;
  logic             done_word;
  pad_state_t       done_st;

  function automatic logic [63:0] bit_len(input logic [LEN_W-1:0] c);
    return 64'(c) << 3;
  endfunction

  // Second chunk of a spilled message: optional terminator, zeros, length.
  function automatic chunk_t tail_chunk(input logic [LEN_W-1:0] c, input logic p);
    chunk_t      t;
    logic [63:0] l;
    t = '0;
    l = bit_len(c);
    if (p) t[0] = SHA256_PAD_WORD;
    t[SHA256_LEN_WORD_IDX]   = l[63:32];
    t[SHA256_LEN_WORD_IDX+1] = l[31:0];
    return t;
  endfunction

  assign n_eff   = msg_last ? clamp_nbytes(msg_nbytes) : 3'd4;
  assign cnt_nx  = cnt + LEN_W'(n_eff);
  assign pend_nx = msg_last && (n_eff == 3'd4) && (widx == 4'd15);
  assign len_nx  = bit_len(cnt_nx);
  assign accept  = msg_vld && msg_rdy;
  assign done_word = accept && (msg_last || (widx == 4'd15));

  sha256_pad_word u_pad_word (
    .data (msg_data),
    .n    (n_eff),
    .word (pword)
  );

  always_comb begin
    if (n_eff != 3'd4)       used = {1'b0, widx} + 5'd1;
    else if (widx == 4'd15)  used = 5'd16;
    else                     used = {1'b0, widx} + 5'd2;
  end

  always_comb begin
    if (!msg_last)           done_st = ST_EMIT;
    else if (used <= 5'd14)  done_st = ST_FINAL;
    else                     done_st = ST_SPILL;
  end

  // Accumulator image after merging the incoming word and, on the last word, its padding.
  always_comb begin
    blk = acc;
    for (int i = 0; i < SHA256_BLOCK_WORDS; i++) begin
      if (5'(i) == {1'b0, widx})
        blk[i] = pword;
      else if (msg_last && (n_eff == 3'd4) && (5'(i) == {1'b0, widx} + 5'd1))
        blk[i] = SHA256_PAD_WORD;
      else if (msg_last && (5'(i) >= used)) begin
        if ((used <= 5'd14) && (i == SHA256_LEN_WORD_IDX))
          blk[i] = len_nx[63:32];
        else if ((used <= 5'd14) && (i == SHA256_LEN_WORD_IDX + 1))
          blk[i] = len_nx[31:0];
        else
          blk[i] = '0;
      end
    end
  end

`ifdef SHA256_PADDER_OBUF_EN
  chunk_t obuf;
  logic   ob_vld;
  logic   ob_last;
  logic   ob_free;

  assign ob_free = !ob_vld || chunk_data_rdy;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= ST_ACCEPT;
      widx    <= '0;
      cnt     <= '0;
      pend    <= 1'b0;
      acc     <= '0;
      obuf    <= '0;
      ob_vld  <= 1'b0;
      ob_last <= 1'b0;
    end else begin
      if (chunk_data_rdy) ob_vld <= 1'b0;
      if (state == ST_ACCEPT) begin
        if (accept) begin
          cnt  <= cnt_nx;
          pend <= pend_nx;
          widx <= widx + 4'd1;
          if (!done_word || !ob_free) begin
            acc <= blk;
            if (done_word) state <= done_st;
          end else begin
            // Completed chunk bypasses the accumulator straight into the free output register.
            obuf    <= blk;
            ob_vld  <= 1'b1;
            ob_last <= (done_st == ST_FINAL);
            if (done_st == ST_SPILL) begin
              acc   <= tail_chunk(cnt_nx, pend_nx);
              state <= ST_FINAL;
            end else if (done_st == ST_FINAL) begin
              widx <= '0;
              cnt  <= '0;
              pend <= 1'b0;
            end
          end
        end
      end else if (ob_free) begin
        obuf    <= acc;
        ob_vld  <= 1'b1;
        ob_last <= (state == ST_FINAL);
        if (state == ST_SPILL) begin
          acc   <= tail_chunk(cnt, pend);
          state <= ST_FINAL;
        end else begin
          widx  <= '0;
          state <= ST_ACCEPT;
          if (state == ST_FINAL) begin
            cnt  <= '0;
            pend <= 1'b0;
          end
        end
      end
    end
  end

  assign msg_rdy        = (state == ST_ACCEPT);
  assign chunk_data_vld = ob_vld;
  assign chunk_last     = ob_last;
  assign chunk_data     = obuf;
`else
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_ACCEPT;
      widx  <= '0;
      cnt   <= '0;
      pend  <= 1'b0;
      acc   <= '0;
    end else begin
      case (state)
        ST_ACCEPT: begin
          if (accept) begin
            acc  <= blk;
            cnt  <= cnt_nx;
            pend <= pend_nx;
            widx <= widx + 4'd1;
            if (done_word) state <= done_st;
          end
        end
        ST_EMIT: begin
          if (chunk_data_rdy) begin
            widx  <= '0;
            state <= ST_ACCEPT;
          end
        end
        ST_SPILL: begin
          if (chunk_data_rdy) begin
            acc   <= tail_chunk(cnt, pend);
            state <= ST_FINAL;
          end
        end
        default: begin
          if (chunk_data_rdy) begin
            widx  <= '0;
            cnt   <= '0;
            pend  <= 1'b0;
            state <= ST_ACCEPT;
          end
        end
      endcase
    end
  end

  assign msg_rdy        = (state == ST_ACCEPT);
  assign chunk_data_vld = (state != ST_ACCEPT);
  assign chunk_last     = (state == ST_FINAL);
  assign chunk_data     = acc;
`endif

endmodule

// File: tb/tb_sha256_padder.sv
// Bench for sha256_padder: directed padding cases plus random messages against a
// byte-level SHA-256 padding model, with random back-pressure on both sides.
module tb_sha256_padder;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              msg_rdy;
  logic              msg_vld = 1'b0;
  logic [31:0]       msg_data = '0;
  logic              msg_last = 1'b0;
  logic [2:0]        msg_nbytes = '0;
  logic              chunk_data_rdy = 1'b0;
  logic              chunk_data_vld;
  logic [15:0][31:0] chunk_data;
  logic              chunk_last;

  int tests = 0;
  int fails = 0;

  logic [31:0]  mw[$];
  logic [2:0]   m_nb;
  logic [511:0] exp_q[$];
  logic [511:0] last_chunk;
  logic [511:0] abc_chunk;

  sha256_padder #(.LEN_W(32)) dut (
    .clk            (clk),
    .rst            (rst),
    .msg_rdy        (msg_rdy),
    .msg_vld        (msg_vld),
    .msg_data       (msg_data),
    .msg_last       (msg_last),
    .msg_nbytes     (msg_nbytes),
    .chunk_data_rdy (chunk_data_rdy),
    .chunk_data_vld (chunk_data_vld),
    .chunk_data     (chunk_data),
    .chunk_last     (chunk_last)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Word 0 of the chunk at the top, i.e. message byte order.
  function automatic logic [511:0] flat(input logic [15:0][31:0] c);
    logic [511:0] r;
    for (int i = 0; i < 16; i++) r[511-32*i -: 32] = c[i];
    return r;
  endfunction

  // Standard SHA-256 padding computed on the message as a byte stream.
  task automatic build_model();
    byte unsigned      b[$];
    int                n;
    longint unsigned   bits;
    n = (m_nb > 3'd4) ? 4 : int'(m_nb);
    for (int j = 0; j < mw.size(); j++) begin
      int k;
      k = (j == mw.size() - 1) ? n : 4;
      for (int x = 0; x < k; x++) b.push_back(mw[j][31-8*x -: 8]);
    end
    bits = longint'(b.size()) * 8;
    b.push_back(8'h80);
    while (b.size() % 64 != 56) b.push_back(8'h00);
    for (int x = 7; x >= 0; x--) b.push_back(bits[8*x +: 8]);
    exp_q.delete();
    for (int c = 0; c < b.size() / 64; c++) begin
      logic [511:0] r;
      r = '0;
      for (int x = 0; x < 64; x++) r = {r[503:0], b[64*c+x]};
      exp_q.push_back(r);
    end
  endtask

  task automatic run_msg(input string tag, input bit stall);
    int           wi = 0;
    int           got = 0;
    int           cyc = 0;
    bit           stalled = 1'b0;
    bit           expect_vld = 1'b0;
    bit           hold = 1'b0;
    logic [511:0] held;
    logic         held_last;
    build_model();
    while (got < exp_q.size() && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      if (expect_vld) check($sformatf("%s latency", tag), 512'(chunk_data_vld), 512'(1));
      expect_vld = 1'b0;
      if (hold) begin
        check($sformatf("%s hold data", tag), flat(chunk_data), held);
        check($sformatf("%s hold last", tag), 512'(chunk_last), 512'(held_last));
      end
      msg_vld        = (wi < mw.size()) && ($urandom_range(3) != 0);
      msg_data       = msg_vld ? mw[wi] : $urandom;
      msg_last       = msg_vld && (wi == mw.size() - 1);
      msg_nbytes     = msg_last ? m_nb : 3'($urandom);
      chunk_data_rdy = ($urandom_range(2) != 0);
      if (stall && !stalled && chunk_data_vld && chunk_last) begin
        stalled = 1'b1;
        chunk_data_rdy = 1'b0;
        held = flat(chunk_data);
        for (int s = 0; s < 10; s++) begin
          @(negedge clk);
          check($sformatf("%s stall data", tag), flat(chunk_data), held);
          check($sformatf("%s stall last", tag), 512'(chunk_last), 512'(1));
          check($sformatf("%s stall msg_rdy", tag), 512'(msg_rdy), 512'(0));
        end
        chunk_data_rdy = 1'b1;
      end
      if (msg_vld && msg_rdy) begin
        if ((wi % 16 == 15) || (wi == mw.size() - 1)) expect_vld = 1'b1;
        wi++;
      end
      hold = 1'b0;
      if (chunk_data_vld) begin
        check($sformatf("%s msg_rdy low", tag), 512'(msg_rdy), 512'(0));
        if (chunk_data_rdy) begin
          last_chunk = flat(chunk_data);
          check($sformatf("%s chunk%0d", tag, got), last_chunk, exp_q[got]);
          check($sformatf("%s last%0d", tag, got), 512'(chunk_last),
                512'(got == exp_q.size() - 1));
          got++;
        end else begin
          hold      = 1'b1;
          held      = flat(chunk_data);
          held_last = chunk_last;
        end
      end
    end
    if (got < exp_q.size()) begin
      tests++;
      fails++;
      $error("FAIL %s timeout: got %0d chunks want %0d", tag, got, exp_q.size());
    end
    @(negedge clk);
    msg_vld        = 1'b0;
    msg_last       = 1'b0;
    chunk_data_rdy = 1'b0;
  endtask

  initial begin
    #1 rst = 1'b0;
    #1;
    check("reset vld", 512'(chunk_data_vld), 512'(0));
    check("reset last", 512'(chunk_last), 512'(0));
    check("reset data", flat(chunk_data), 512'(0));
    #20;
    @(negedge clk) rst = 1'b1;
    @(negedge clk);
    check("reset msg_rdy", 512'(msg_rdy), 512'(1));

    mw = '{32'h0000_0000};
    m_nb = 3'd0;
    run_msg("empty", 1'b0);
    check("empty exact", last_chunk, {32'h8000_0000, 480'h0});

    mw = '{32'h6162_6300};
    m_nb = 3'd3;
    run_msg("abc", 1'b0);
    abc_chunk = last_chunk;
    check("abc w0", 512'(last_chunk[511:480]), 512'(32'h6162_6380));
    check("abc w15", 512'(last_chunk[31:0]), 512'(32'h0000_0018));

    mw.delete();
    for (int k = 0; k < 14; k++) mw.push_back($urandom);
    m_nb = 3'd4;
    run_msg("56B", 1'b0);
    check("56B w15", 512'(last_chunk[31:0]), 512'(32'h0000_01C0));

    mw.delete();
    for (int k = 0; k < 16; k++) mw.push_back($urandom);
    m_nb = 3'd4;
    run_msg("64B", 1'b0);
    check("64B w15", 512'(last_chunk[31:0]), 512'(32'h0000_0200));

    mw.delete();
    for (int k = 0; k < 3; k++) mw.push_back($urandom);
    m_nb = 3'd2;
    run_msg("stall", 1'b1);

    @(negedge clk);
    msg_vld = 1'b1;
    msg_last = 1'b0;
    msg_nbytes = 3'd4;
    for (int k = 0; k < 5; k++) begin
      msg_data = $urandom;
      @(negedge clk);
    end
    msg_vld = 1'b0;
    rst = 1'b0;
    #1;
    check("midrst vld", 512'(chunk_data_vld), 512'(0));
    check("midrst data", flat(chunk_data), 512'(0));
    @(negedge clk) rst = 1'b1;
    mw = '{32'h6162_6300};
    m_nb = 3'd3;
    run_msg("abc2", 1'b0);
    check("abc2 same", last_chunk, abc_chunk);

    for (int t = 0; t < 25; t++) begin
      int nw;
      nw = $urandom_range(40, 1);
      mw.delete();
      for (int k = 0; k < nw; k++) mw.push_back($urandom);
      m_nb = 3'($urandom);
      run_msg($sformatf("rnd%0d", t), 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/sha256_padder.md
SHA256_PADDER -- requirements
Module: sha256_padder

Interface
REQ-001 SHALL have parameter LEN_W, default 32: width of the message byte counter; zero-extended into the 64-bit length field.
REQ-002 SHALL have port clk  input  1  sole clock, rising edge.
REQ-003 SHALL have port rst  input  1  reset; one clock; reset is asynchronous and active-low.
REQ-004 SHALL have port msg_rdy  output  1  word accepted when msg_rdy & msg_vld.
REQ-005 SHALL have port msg_vld  input  1  msg_data/msg_last/msg_nbytes valid.
REQ-006 SHALL have port msg_data  input  32  big-endian message word; byte 0 in [31:24].
REQ-007 SHALL have port msg_last  input  1  final word of message.
REQ-008 SHALL have port msg_nbytes  input  3  valid bytes in last word, 0..4; ignored (treated as 4) when msg_last=0.
REQ-009 SHALL have port chunk_data_rdy  input  1  downstream (sha256_transform) ready.
REQ-010 SHALL have port chunk_data_vld  output  1  chunk valid.
REQ-011 SHALL have port chunk_data  output  16x32  padded 512-bit chunk; word 0 first.
REQ-012 SHALL have port chunk_last  output  1  chunk is the final one of its message.

Function
REQ-013 SHALL implement FSM ACCEPT, EMIT, SPILL, FINAL; reset state ACCEPT.
REQ-014 ACCEPT: msg_rdy=1; each accepted word written at index widx, widx++, byte counter += bytes contributed (4, or msg_nbytes on last).
REQ-015 Non-last word at widx=15 SHALL go to EMIT; EMIT outputs chunk, chunk_last=0, returns to ACCEPT with widx=0 on handshake.
REQ-016 Last word, n=msg_nbytes<4: word keeps top n bytes, zeroes the rest, 0x80 at byte n; used=widx+1.
REQ-017 Last word, n=4: word stored unmodified; if widx<15, word widx+1=0x80000000, used=widx+2; if widx=15, terminator pending, used=16.
REQ-018 After last word: used<=14 -> FINAL; else -> SPILL.
REQ-019 SPILL: words used..15 zero, chunk_last=0; on handshake -> FINAL with word0=0x80000000 if terminator pending, else all zero.
REQ-020 FINAL: words after padding through 13 zero, words 14/15 = 64-bit big-endian bit length (bytes<<3), chunk_last=1; on handshake byte counter, widx, pending cleared, -> ACCEPT.
REQ-021 Latency: chunk_data_vld asserted the cycle after the completing word's handshake; one bubble per chunk.
REQ-022 chunk_data, chunk_last SHALL hold stable while chunk_data_vld & !chunk_data_rdy.
REQ-023 msg_rdy SHALL be 0 outside ACCEPT (macro off).
REQ-024 Byte counter SHALL wrap modulo 2^LEN_W; longer messages unsupported.
REQ-025 msg_nbytes>4 SHALL be treated as 4.

Reset
REQ-026 Reset assertion SHALL immediately force state=ACCEPT, widx=0, counter=0, pending=0, chunk_data_vld=0, chunk_last=0, msg_rdy=1 (after release), chunk_data=0.
REQ-027 Reset mid-message SHALL discard partial data; next message padded independently. Release is synchronised externally.

Configuration
REQ-028 SHA256_PADDER_OBUF_EN defined: separate output chunk register; accumulator keeps accepting while output register occupied; msg_rdy drops only when a chunk completes with output register still full; zero bubbles under continuous rdy.
REQ-029 SHA256_PADDER_OBUF_EN undefined: single buffer, behaviour per REQ-021/023.

Structure
REQ-030 sha256_pkg SHALL hold SHA256_BLOCK_WORDS=16, SHA256_PAD_WORD=32'h8000_0000, SHA256_LEN_WORD_IDX=14, and the padder state enum.
REQ-031 Byte-masking/terminator insertion SHALL be sub-module sha256_pad_word (combinational: data, n -> padded word).

Verification
REQ-032 Empty message: first word last, nbytes=0 -> one chunk, w0=80000000, w1..15=0, chunk_last=1.
REQ-033 "abc": 61626300 nbytes=3 -> w0=61626380, w15=00000018, chunk_last=1; downstream hash ba7816bf...15ad.
REQ-034 56 bytes (14 words, last nbytes=4) -> chunk1 w14=80000000, w15=0, last=0; chunk2 w0..14=0, w15=000001C0, last=1.
REQ-035 64 bytes (16 words) -> chunk1 data only, last=0; chunk2 w0=80000000, w15=00000200, last=1.
REQ-036 chunk_data_rdy=0 for 10 cycles during FINAL -> outputs stable, msg_rdy=0 (macro off); with macro, next message words accepted.
REQ-037 rst low after 5 words, then "abc" -> single chunk identical to REQ-033.
